// File: rtl/fetch_miss_queue_pkg.sv
// fetch_miss_queue_pkg: shared types and defaults for the fetch-miss queue
package fetch_miss_queue_pkg;
  localparam int FMQ_ENTRIES = 4;
  localparam int FMID_WIDTH = 2;
  localparam int PA_WIDTH = 32;
  typedef enum logic [1:0] {FREE, REQ_PEND, WAIT_RESP, KILLED} fmq_state_t;
  typedef logic [FMID_WIDTH-1:0] fmid_t;
  typedef logic [127:0] fetch16B_t;
  typedef struct packed {
    fmq_state_t state;
    fmid_t fmid;
    logic [PA_WIDTH-5:0] pa16;
  } fmq_entry_t;
endpackage

// File: rtl/fetch_miss_queue_pe_lsb.sv
// pe_lsb: lowest-set-bit priority encoder with any-set flag
module pe_lsb #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
  assign valid = |req;
endmodule

// File: rtl/fetch_miss_queue.sv
// fetch_miss_queue: tracks fetch misses, issues 64B L2 line requests and
// returns the addressed 16B chunk to the ibuffer one cycle after the response.
module fetch_miss_queue
  import fetch_miss_queue_pkg::*;
#(
  parameter int FMQ_ENTRIES = fetch_miss_queue_pkg::FMQ_ENTRIES,
  parameter int FMID_WIDTH = fetch_miss_queue_pkg::FMID_WIDTH,
  parameter int PA_WIDTH = fetch_miss_queue_pkg::PA_WIDTH,
  localparam int IDW = $clog2(FMQ_ENTRIES)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  miss_req_valid,
  input  logic [FMID_WIDTH-1:0] miss_req_fmid,
  input  logic [PA_WIDTH-5:0]   miss_req_pa16,
  output logic                  miss_req_ready,
  output logic                  l2_req_valid,
  output logic [IDW-1:0]        l2_req_id,
  output logic [PA_WIDTH-7:0]   l2_req_line_pa,
  input  logic                  l2_req_ready,
  input  logic                  l2_resp_valid,
  input  logic [IDW-1:0]        l2_resp_id,
  input  logic [511:0]          l2_resp_data,
  output logic                  fetch_miss_return_valid,
  output logic [FMID_WIDTH-1:0] fetch_miss_return_fmid,
  output fetch16B_t             fetch_miss_return_fetch16B,
  input  logic                  restart_valid
);
  typedef struct packed {
    fmq_state_t state;
    logic [FMID_WIDTH-1:0] fmid;
    logic [PA_WIDTH-5:0] pa16;
  } entry_t;
  entry_t ent [FMQ_ENTRIES];
  entry_t ent_nxt [FMQ_ENTRIES];
  logic [FMQ_ENTRIES-1:0] free_vec, pend_vec;
  logic [IDW-1:0] alloc_idx, sel_idx, req_idx, lock_idx;
  logic alloc_any, sel_any, lock_valid, alloc_fire, req_fire;
  fmq_state_t rsp_state;
  logic [FMID_WIDTH-1:0] rsp_fmid;
  logic [1:0] rsp_chunk;
  always_comb begin
    free_vec = '0;
    pend_vec = '0;
    for (int i = 0; i < FMQ_ENTRIES; i++) begin
      free_vec[i] = ent[i].state == FREE;
      pend_vec[i] = ent[i].state == REQ_PEND;
    end
  end
  pe_lsb #(.N(FMQ_ENTRIES)) u_alloc_pe (.req(free_vec), .idx(alloc_idx), .valid(alloc_any));
  pe_lsb #(.N(FMQ_ENTRIES)) u_req_pe (.req(pend_vec), .idx(sel_idx), .valid(sel_any));
  assign miss_req_ready = alloc_any & ~restart_valid;
  assign alloc_fire = miss_req_valid & miss_req_ready;
  // a stalled request keeps its slot even if a lower entry becomes pending
  assign req_idx = lock_valid ? lock_idx : sel_idx;
  assign l2_req_valid = lock_valid | sel_any;
  assign l2_req_id = req_idx;
  assign l2_req_line_pa = ent[req_idx].pa16[PA_WIDTH-5:2];
  assign req_fire = l2_req_valid & l2_req_ready;
  assign rsp_state = ent[l2_resp_id].state;
  assign rsp_fmid = ent[l2_resp_id].fmid;
  assign rsp_chunk = ent[l2_resp_id].pa16[1:0];
  always_comb begin
    for (int i = 0; i < FMQ_ENTRIES; i++) begin
      ent_nxt[i] = ent[i];
      if (alloc_fire && alloc_idx == IDW'(i))
        ent_nxt[i] = '{state: REQ_PEND, fmid: miss_req_fmid, pa16: miss_req_pa16};
      else if (l2_resp_valid && l2_resp_id == IDW'(i) && ent[i].state inside {WAIT_RESP, KILLED})
        ent_nxt[i].state = FREE;
      else if (req_fire && req_idx == IDW'(i))
        ent_nxt[i].state = restart_valid ? KILLED : WAIT_RESP;
      else if (restart_valid)
        ent_nxt[i].state = ent[i].state == REQ_PEND ? FREE :
                           ent[i].state == WAIT_RESP ? KILLED : ent[i].state;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FMQ_ENTRIES; i++) ent[i] <= '0;
      lock_valid <= 1'b0;
      lock_idx <= '0;
      fetch_miss_return_valid <= 1'b0;
      fetch_miss_return_fmid <= '0;
      fetch_miss_return_fetch16B <= '0;
    end else begin
      for (int i = 0; i < FMQ_ENTRIES; i++) ent[i] <= ent_nxt[i];
      lock_valid <= l2_req_valid & ~l2_req_ready & ~restart_valid;
      lock_idx <= req_idx;
      fetch_miss_return_valid <= l2_resp_valid & (rsp_state == WAIT_RESP) & ~restart_valid;
      if (l2_resp_valid) begin
        fetch_miss_return_fmid <= rsp_fmid;
        fetch_miss_return_fetch16B <= l2_resp_data[{rsp_chunk, 7'b0} +: 128];
      end
    end
  end
  a_resp_live: assert property (@(posedge CLK) disable iff (!nRST)
    l2_resp_valid |-> rsp_state inside {WAIT_RESP, KILLED});
endmodule

// File: tb/tb_fetch_miss_queue.sv
// tb_fetch_miss_queue: directed self-checking bench for fetch_miss_queue
module tb_fetch_miss_queue;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic miss_req_valid, miss_req_ready, l2_req_valid, l2_req_ready;
  logic l2_resp_valid, fetch_miss_return_valid, restart_valid;
  logic [1:0] miss_req_fmid, l2_req_id, l2_resp_id, fetch_miss_return_fmid;
  logic [27:0] miss_req_pa16;
  logic [25:0] l2_req_line_pa;
  logic [511:0] l2_resp_data;
  logic [127:0] fetch_miss_return_fetch16B;
  int checks = 0;
  int failures = 0;

  fetch_miss_queue dut (
    .CLK(CLK), .nRST(nRST),
    .miss_req_valid(miss_req_valid), .miss_req_fmid(miss_req_fmid),
    .miss_req_pa16(miss_req_pa16), .miss_req_ready(miss_req_ready),
    .l2_req_valid(l2_req_valid), .l2_req_id(l2_req_id),
    .l2_req_line_pa(l2_req_line_pa), .l2_req_ready(l2_req_ready),
    .l2_resp_valid(l2_resp_valid), .l2_resp_id(l2_resp_id), .l2_resp_data(l2_resp_data),
    .fetch_miss_return_valid(fetch_miss_return_valid),
    .fetch_miss_return_fmid(fetch_miss_return_fmid),
    .fetch_miss_return_fetch16B(fetch_miss_return_fetch16B),
    .restart_valid(restart_valid)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle;
    miss_req_valid = 1'b0;
    miss_req_fmid = '0;
    miss_req_pa16 = '0;
    l2_req_ready = 1'b0;
    l2_resp_valid = 1'b0;
    l2_resp_id = '0;
    l2_resp_data = '0;
    restart_valid = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    nRST = 1'b0;
    #12;
    nRST = 1'b1;
    tick();
  endtask

  task automatic miss(input logic [1:0] f, input logic [27:0] pa);
    miss_req_valid = 1'b1;
    miss_req_fmid = f;
    miss_req_pa16 = pa;
    tick();
    miss_req_valid = 1'b0;
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] s);
    logic [511:0] l;
    for (int c = 0; c < 4; c++) l[128*c +: 128] = {4{s + 32'(c)}};
    return l;
  endfunction

  task automatic test_reset;
    idle();
    nRST = 1'b0;
    #3;
    checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL reset_l2_valid got=%0b exp=0", l2_req_valid); end
    checks++; if (fetch_miss_return_valid !== 1'b0) begin failures++; $display("FAIL reset_ret_valid got=%0b exp=0", fetch_miss_return_valid); end
    checks++; if (fetch_miss_return_fetch16B !== 128'd0 || fetch_miss_return_fmid !== 2'd0) begin failures++; $display("FAIL reset_ret_data got=%0h/%0h exp=0/0", fetch_miss_return_fmid, fetch_miss_return_fetch16B); end
    #9;
    nRST = 1'b1;
    tick();
    checks++; if (miss_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", miss_req_ready); end
    checks++; if (l2_req_id !== 2'd0 || l2_req_line_pa !== 26'd0) begin failures++; $display("FAIL reset_l2_req got=%0h/%0h exp=0/0", l2_req_id, l2_req_line_pa); end
  endtask

  task automatic test_single;
    do_reset();
    l2_req_ready = 1'b1;
    miss_req_valid = 1'b1; miss_req_fmid = 2'd1; miss_req_pa16 = 28'h0001003;
    #1;
    checks++; if (miss_req_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b exp=1", miss_req_ready); end
    tick();
    miss_req_valid = 1'b0;
    #1;
    checks++; if (l2_req_valid !== 1'b1 || l2_req_id !== 2'd0) begin failures++; $display("FAIL single_req got=%0b/%0d exp=1/0", l2_req_valid, l2_req_id); end
    checks++; if (l2_req_line_pa !== 26'h0000400) begin failures++; $display("FAIL single_line_pa got=%0h exp=400", l2_req_line_pa); end
    tick();
    checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL single_req_done got=%0b exp=0", l2_req_valid); end
    l2_resp_valid = 1'b1; l2_resp_id = 2'd0;
    l2_resp_data = {{32{4'hA}}, {32{4'h3}}, {32{4'h2}}, {32{4'h1}}};
    tick();
    l2_resp_valid = 1'b0;
    checks++; if (fetch_miss_return_valid !== 1'b1 || fetch_miss_return_fmid !== 2'd1) begin failures++; $display("FAIL single_ret got=%0b/%0d exp=1/1", fetch_miss_return_valid, fetch_miss_return_fmid); end
    checks++; if (fetch_miss_return_fetch16B !== {32{4'hA}}) begin failures++; $display("FAIL single_chunk got=%0h exp=aaaa..", fetch_miss_return_fetch16B); end
    tick();
    checks++; if (fetch_miss_return_valid !== 1'b0) begin failures++; $display("FAIL single_ret_drop got=%0b exp=0", fetch_miss_return_valid); end
    l2_req_ready = 1'b0;
    miss(2'd2, 28'h0002000);
    #1;
    checks++; if (l2_req_id !== 2'd0 || l2_req_line_pa !== 26'h0000800) begin failures++; $display("FAIL single_reuse got=%0d/%0h exp=0/800", l2_req_id, l2_req_line_pa); end
  endtask

  task automatic test_fill;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      miss_req_valid = 1'b1; miss_req_fmid = 2'(k); miss_req_pa16 = 28'(32'h100 * k + k);
      #1;
      checks++; if (miss_req_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_%0d got=%0b exp=1", k, miss_req_ready); end
      tick();
    end
    miss_req_valid = 1'b0;
    #1;
    checks++; if (miss_req_ready !== 1'b0) begin failures++; $display("FAIL fill_full got=%0b exp=0", miss_req_ready); end
    tick(); tick();
    checks++; if (l2_req_valid !== 1'b1 || l2_req_id !== 2'd0 || l2_req_line_pa !== 26'd0) begin failures++; $display("FAIL fill_hold got=%0b/%0d/%0h exp=1/0/0", l2_req_valid, l2_req_id, l2_req_line_pa); end
    l2_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (l2_req_valid !== 1'b1 || l2_req_id !== 2'(k) || l2_req_line_pa !== 26'(32'h40 * k)) begin failures++; $display("FAIL fill_issue_%0d got=%0b/%0d/%0h exp=1/%0d/%0h", k, l2_req_valid, l2_req_id, l2_req_line_pa, k, 32'h40 * k); end
      tick();
    end
    checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL fill_drained got=%0b exp=0", l2_req_valid); end
  endtask

  task automatic test_out_of_order;
    int order [4] = '{2, 0, 3, 1};
    logic [31:0] seed;
    for (int j = 0; j < 4; j++) begin
      seed = 32'h1000_0000 + 32'(j * 16);
      l2_resp_valid = 1'b1; l2_resp_id = 2'(order[j]); l2_resp_data = mk_line(seed);
      tick();
      checks++; if (fetch_miss_return_valid !== 1'b1 || fetch_miss_return_fmid !== 2'(order[j])) begin failures++; $display("FAIL ooo_ret_%0d got=%0b/%0d exp=1/%0d", j, fetch_miss_return_valid, fetch_miss_return_fmid, order[j]); end
      checks++; if (fetch_miss_return_fetch16B !== {4{seed + 32'(order[j])}}) begin failures++; $display("FAIL ooo_chunk_%0d got=%0h exp=%0h", j, fetch_miss_return_fetch16B, {4{seed + 32'(order[j])}}); end
    end
    l2_resp_valid = 1'b0;
    tick();
    checks++; if (fetch_miss_return_valid !== 1'b0 || miss_req_ready !== 1'b1) begin failures++; $display("FAIL ooo_end got=%0b/%0b exp=0/1", fetch_miss_return_valid, miss_req_ready); end
  endtask

  task automatic test_restart;
    do_reset();
    l2_req_ready = 1'b1;
    miss(2'd0, 28'h10); tick();
    miss(2'd1, 28'h20); tick();
    l2_req_ready = 1'b0;
    miss(2'd2, 28'h30);
    #1;
    checks++; if (l2_req_valid !== 1'b1 || l2_req_id !== 2'd2) begin failures++; $display("FAIL rst_pre got=%0b/%0d exp=1/2", l2_req_valid, l2_req_id); end
    restart_valid = 1'b1;
    #1;
    checks++; if (miss_req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", miss_req_ready); end
    tick();
    restart_valid = 1'b0;
    #1;
    checks++; if (l2_req_valid !== 1'b0 || miss_req_ready !== 1'b1) begin failures++; $display("FAIL rst_post got=%0b/%0b exp=0/1", l2_req_valid, miss_req_ready); end
    for (int k = 0; k < 2; k++) begin
      l2_resp_valid = 1'b1; l2_resp_id = 2'(k); l2_resp_data = mk_line(32'h55);
      tick();
      checks++; if (fetch_miss_return_valid !== 1'b0) begin failures++; $display("FAIL rst_killed_%0d got=%0b exp=0", k, fetch_miss_return_valid); end
    end
    l2_resp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      miss_req_valid = 1'b1; miss_req_fmid = 2'(k); miss_req_pa16 = 28'(k);
      #1;
      checks++; if (miss_req_ready !== 1'b1) begin failures++; $display("FAIL rst_freed_%0d got=%0b exp=1", k, miss_req_ready); end
      tick();
    end
    miss_req_valid = 1'b0;
    #1;
    checks++; if (miss_req_ready !== 1'b0 || l2_req_id !== 2'd0) begin failures++; $display("FAIL rst_refill got=%0b/%0d exp=0/0", miss_req_ready, l2_req_id); end
  endtask

  task automatic test_restart_same_cycle;
    do_reset();
    l2_req_ready = 1'b1;
    miss(2'd3, 28'h0000042);
    tick();
    l2_req_ready = 1'b0;
    restart_valid = 1'b1;
    l2_resp_valid = 1'b1; l2_resp_id = 2'd0; l2_resp_data = mk_line(32'h77);
    miss_req_valid = 1'b1; miss_req_fmid = 2'd2; miss_req_pa16 = 28'h0000100;
    #1;
    checks++; if (miss_req_ready !== 1'b0) begin failures++; $display("FAIL same_ready got=%0b exp=0", miss_req_ready); end
    tick();
    idle();
    #1;
    checks++; if (fetch_miss_return_valid !== 1'b0) begin failures++; $display("FAIL same_ret got=%0b exp=0", fetch_miss_return_valid); end
    checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL same_miss_taken got=%0b exp=0", l2_req_valid); end
    miss(2'd1, 28'h0000200);
    #1;
    checks++; if (l2_req_valid !== 1'b1 || l2_req_id !== 2'd0 || l2_req_line_pa !== 26'h80) begin failures++; $display("FAIL same_freed got=%0b/%0d/%0h exp=1/0/80", l2_req_valid, l2_req_id, l2_req_line_pa); end
  endtask

  task automatic test_lock;
    do_reset();
    l2_req_ready = 1'b1;
    miss(2'd0, 28'h0000010);
    tick();
    l2_req_ready = 1'b0;
    miss(2'd1, 28'h0000020);
    l2_resp_valid = 1'b1; l2_resp_id = 2'd0; l2_resp_data = mk_line(32'h99);
    tick();
    l2_resp_valid = 1'b0;
    checks++; if (fetch_miss_return_valid !== 1'b1 || fetch_miss_return_fmid !== 2'd0) begin failures++; $display("FAIL lock_ret got=%0b/%0d exp=1/0", fetch_miss_return_valid, fetch_miss_return_fmid); end
    miss(2'd2, 28'h0000030);
    #1;
    checks++; if (l2_req_id !== 2'd1 || l2_req_line_pa !== 26'h8) begin failures++; $display("FAIL lock_hold got=%0d/%0h exp=1/8", l2_req_id, l2_req_line_pa); end
    tick();
    checks++; if (l2_req_id !== 2'd1) begin failures++; $display("FAIL lock_hold2 got=%0d exp=1", l2_req_id); end
    l2_req_ready = 1'b1;
    tick();
    checks++; if (l2_req_valid !== 1'b1 || l2_req_id !== 2'd0 || l2_req_line_pa !== 26'hC) begin failures++; $display("FAIL lock_next got=%0b/%0d/%0h exp=1/0/c", l2_req_valid, l2_req_id, l2_req_line_pa); end
    tick();
    checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL lock_done got=%0b exp=0", l2_req_valid); end
  endtask

  task automatic test_async_reset;
    do_reset();
    miss(2'd1, 28'h0000400);
    #1;
    checks++; if (l2_req_valid !== 1'b1) begin failures++; $display("FAIL areset_pre got=%0b exp=1", l2_req_valid); end
    nRST = 1'b0;
    #1;
    checks++; if (l2_req_valid !== 1'b0 || miss_req_ready !== 1'b1) begin failures++; $display("FAIL areset_clear got=%0b/%0b exp=0/1", l2_req_valid, miss_req_ready); end
    nRST = 1'b1;
    tick();
    checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL areset_post got=%0b exp=0", l2_req_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_out_of_order();
    test_restart();
    test_restart_same_cycle();
    test_lock();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
